// File: rtl/imem_stream_loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory stream loader.
package imem_stream_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StBytes,
    StWrite,
    StFinish
  } state_e;

  localparam int unsigned HdrBytes     = 2;
  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned ByteIdxW     = $clog2(BytesPerWord);

  // A header count larger than the 2^pc_size loadable words is flagged but still consumed.
  function automatic logic count_overflows(input logic [8*HdrBytes-1:0] cnt,
                                           input int unsigned pc_size);
    return 32'(cnt) > (32'd1 << pc_size);
  endfunction

endpackage

// File: rtl/imem_stream_loader_byte_word_packer.sv
// Assembles little-endian bytes into a 32-bit word; byte k lands in bits [8k+7:8k].
module imem_stream_loader_byte_word_packer
  import imem_stream_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [ByteIdxW-1:0] idx_q;
  logic [31:0]         word_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
    end else if (load_i) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      idx_q                        <= idx_q + ByteIdxW'(1);
    end
  end

  // High while the next loaded byte completes the word.
  assign word_full_o = (idx_q == ByteIdxW'(BytesPerWord - 1));
  assign word_o      = word_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Streams a length-prefixed byte image into the core's instruction memory, holding the core
// in reset for the duration of the load.
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int unsigned PC_SIZE = 10,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [31:0]        instruction_in,
  output logic [PC_SIZE-1:0] PC_write,
  output logic               reset_IF_memory,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_e                state_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      words_q;
  logic [CNT_W-1:0]      words_next;
  logic [PC_SIZE:0]      pc_q;
  logic                  strobe_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [8*HdrBytes-1:0] hdr_count;
  logic                  xfer;
  logic                  pack_clear;
  logic                  pack_load;
  logic                  word_full;

  assign s_ready    = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StBytes);
  assign xfer       = s_valid & s_ready;
  assign hdr_count  = {s_data, count_q[7:0]};
  assign words_next = words_q + CNT_W'(1);
  assign pack_clear = (state_q == StLenHi) & xfer;
  assign pack_load  = (state_q == StBytes) & xfer;

  imem_stream_loader_byte_word_packer u_packer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clear_i    (pack_clear),
    .load_i     (pack_load),
    .byte_i     (s_data),
    .word_o     (instruction_in),
    .word_full_o(word_full)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      words_q  <= '0;
      pc_q     <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLenLo;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            pc_q    <= '0;
            words_q <= '0;
          end
        end
        StLenLo: begin
          if (xfer) begin
            count_q[7:0] <= s_data;
            state_q      <= StLenHi;
          end
        end
        StLenHi: begin
          if (xfer) begin
            count_q <= CNT_W'(hdr_count);
            if (count_overflows(hdr_count, PC_SIZE)) error_q <= 1'b1;
            if (hdr_count == '0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StBytes;
            end
          end
        end
        StBytes: begin
          if (xfer && word_full) begin
            state_q  <= StWrite;
            strobe_q <= ~pc_q[PC_SIZE];
          end
        end
        StWrite: begin
          words_q <= words_next;
          if (!pc_q[PC_SIZE]) pc_q <= pc_q + (PC_SIZE + 1)'(1);
          if (words_next == count_q) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end else begin
            state_q <= StBytes;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // pc_q's top bit marks running past the end of memory; PC_write then sticks at the last index.
  assign PC_write        = pc_q[PC_SIZE] ? '1 : pc_q[PC_SIZE-1:0];
  assign reset_IF_memory = strobe_q;
  assign core_hold       = busy_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: directed scenarios plus randomized loads against
// a word-list reference model.
module tb_imem_stream_loader;

  localparam int unsigned PcSize = 2;
  localparam int unsigned Depth  = 4;
  localparam int          Budget = 400;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       instruction_in;
  logic [PcSize-1:0] PC_write;
  logic              reset_IF_memory;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clock = ~clock;

  imem_stream_loader #(
    .PC_SIZE(PcSize),
    .CNT_W  (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .instruction_in (instruction_in),
    .PC_write       (PC_write),
    .reset_IF_memory(reset_IF_memory),
    .core_hold      (core_hold),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  int checks = 0;
  int errors = 0;

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          ready_in_wr = 0;
  int          hdr_err = -1;
  int          acc_cyc_q[$];
  int          wr_cyc_q[$];
  int unsigned wr_pc_q[$];
  logic [31:0] wr_word_q[$];

  always @(negedge clock) begin
    cyc++;
    if (acc_cyc_q.size() == 2 && cyc == acc_cyc_q[1] + 1) hdr_err = int'(error);
    if (reset_IF_memory) begin
      wr_cyc_q.push_back(cyc);
      wr_pc_q.push_back(int'(PC_write));
      wr_word_q.push_back(instruction_in);
      if (s_ready) ready_in_wr++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_valid && s_ready) acc_cyc_q.push_back(cyc);
  end

  // Reference model: the image is a list of little-endian words; only the first Depth are written.
  logic [7:0]  data_q[$];
  int unsigned exp_pc_q[$];
  logic [31:0] exp_word_q[$];
  logic [31:0] exp_last;

  task automatic build_model(input int cnt);
    logic [31:0] w;
    exp_pc_q.delete();
    exp_word_q.delete();
    exp_last = 32'h0;
    for (int i = 0; i < cnt; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) w = w + (32'(data_q[4*i+k]) << (8 * k));
      if (i < int'(Depth)) begin
        exp_pc_q.push_back(i);
        exp_word_q.push_back(w);
      end
      exp_last = w;
    end
  endtask

  task automatic fill_data(input int cnt);
    data_q.delete();
    for (int i = 0; i < 4 * cnt; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int budget;
    budget = Budget;
    if (toggle) begin
      s_valid = 1'b0;
      step();
    end
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL send_byte: s_ready never rose within %0d cycles", Budget);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic do_load(input int cnt, input bit toggle, input bit mid_start);
    logic [15:0] c16;
    int          budget;
    c16 = 16'(cnt);
    acc_cyc_q.delete();
    wr_cyc_q.delete();
    wr_pc_q.delete();
    wr_word_q.delete();
    hdr_err = -1;
    start   = 1'b1;
    step();
    start = 1'b0;
    send_byte(c16[7:0], toggle);
    send_byte(c16[15:8], toggle);
    for (int i = 0; i < data_q.size(); i++) begin
      if (mid_start && i == 2) start = 1'b1;
      send_byte(data_q[i], toggle);
      start = 1'b0;
    end
    budget = Budget;
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: busy still %0b after %0d cycles", busy, Budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({s_ready, reset_IF_memory, core_hold, busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {s_ready, reset_IF_memory, core_hold, busy, done, error});
    end
    checks++;
    if ({instruction_in, PC_write} !== '0) begin
      errors++;
      $display("FAIL reset_data: instr %h pc %0d want 0/0", instruction_in, PC_write);
    end
    reset = 1'b1;
    step();
    checks++;
    if (wr_word_q.size() !== 0 || reset_IF_memory !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe: %0d strobes seen, want 0", wr_word_q.size());
    end
  endtask

  task automatic test_basic();
    int d0;
    d0     = done_cnt;
    data_q = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    do_load(2, 1'b0, 1'b0);
    checks++;
    if (wr_word_q.size() !== 2) begin
      errors++;
      $display("FAIL basic_count: %0d strobes want 2", wr_word_q.size());
    end
    if (wr_word_q.size() >= 2 && acc_cyc_q.size() >= 10) begin
      checks++;
      if (wr_word_q[0] !== 32'h00100013 || wr_pc_q[0] !== 0) begin
        errors++;
        $display("FAIL basic_w0: %h@%0d want 00100013@0", wr_word_q[0], wr_pc_q[0]);
      end
      checks++;
      if (wr_word_q[1] !== 32'h00200093 || wr_pc_q[1] !== 1) begin
        errors++;
        $display("FAIL basic_w1: %h@%0d want 00200093@1", wr_word_q[1], wr_pc_q[1]);
      end
      checks++;
      if (wr_cyc_q[0] !== acc_cyc_q[5] + 1 || acc_cyc_q[6] !== acc_cyc_q[5] + 2) begin
        errors++;
        $display("FAIL basic_latency: strobe %0d next %0d after byte %0d, want +1/+2",
                 wr_cyc_q[0], acc_cyc_q[6], acc_cyc_q[5]);
      end
      checks++;
      if (done_cyc !== wr_cyc_q[1] + 1) begin
        errors++;
        $display("FAIL basic_done_time: done at %0d want %0d", done_cyc, wr_cyc_q[1] + 1);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || core_hold !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_finish: done %0d hold %b busy %b want 1/0/0",
               done_cnt - d0, core_hold, busy);
    end
    checks++;
    if (PC_write !== 2'd2 || instruction_in !== 32'h00200093) begin
      errors++;
      $display("FAIL basic_hold: pc %0d instr %h want 2/00200093", PC_write, instruction_in);
    end
  endtask

  task automatic test_zero_count();
    int d0;
    d0 = done_cnt;
    data_q.delete();
    do_load(0, 1'b0, 1'b0);
    checks++;
    if (wr_word_q.size() !== 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: %0d strobes err %b want 0/0", wr_word_q.size(), error);
    end
    checks++;
    if (done_cnt - d0 !== 1 || acc_cyc_q.size() !== 2 || done_cyc !== acc_cyc_q[1] + 1) begin
      errors++;
      $display("FAIL zero_done: pulses %0d at %0d want 1 at hdr+1", done_cnt - d0, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    r0     = ready_in_wr;
    data_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(1, 1'b1, 1'b0);
    checks++;
    if (wr_word_q.size() !== 1) begin
      errors++;
      $display("FAIL bp_count: %0d strobes want 1", wr_word_q.size());
    end else begin
      checks++;
      if (wr_word_q[0] !== 32'hDEADBEEF || wr_pc_q[0] !== 0) begin
        errors++;
        $display("FAIL bp_word: %h@%0d want deadbeef@0", wr_word_q[0], wr_pc_q[0]);
      end
    end
    checks++;
    if (ready_in_wr !== r0) begin
      errors++;
      $display("FAIL bp_ready_in_write: s_ready high in %0d write cycles want 0",
               ready_in_wr - r0);
    end
  endtask

  task automatic test_overflow();
    int d0;
    d0 = done_cnt;
    fill_data(5);
    build_model(5);
    do_load(5, 1'b0, 1'b0);
    checks++;
    if (hdr_err !== 1) begin
      errors++;
      $display("FAIL ovf_hdr_err: error %0d after header want 1", hdr_err);
    end
    checks++;
    if (wr_word_q.size() !== 4 || acc_cyc_q.size() !== 22 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL ovf_counts: strobes %0d bytes %0d done %0d want 4/22/1",
               wr_word_q.size(), acc_cyc_q.size(), done_cnt - d0);
    end
    for (int i = 0; i < wr_word_q.size() && i < exp_word_q.size(); i++) begin
      checks++;
      if (wr_word_q[i] !== exp_word_q[i] || wr_pc_q[i] !== exp_pc_q[i]) begin
        errors++;
        $display("FAIL ovf_word%0d: %h@%0d want %h@%0d", i, wr_word_q[i], wr_pc_q[i],
                 exp_word_q[i], exp_pc_q[i]);
      end
    end
    repeat (3) step();
    checks++;
    if (error !== 1'b1 || PC_write !== 2'd3 || instruction_in !== exp_last) begin
      errors++;
      $display("FAIL ovf_sticky: err %b pc %0d instr %h want 1/3/%h", error, PC_write,
               instruction_in, exp_last);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear_on_start: err %b busy %b want 0/1", error, busy);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    wr_word_q.delete();
    reset = 1'b0;
    step();
    checks++;
    if ({s_ready, reset_IF_memory, core_hold, busy, done, error} !== 6'b0 ||
        {instruction_in, PC_write} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ctrl %b instr %h pc %0d want all 0",
               {s_ready, reset_IF_memory, core_hold, busy, done, error}, instruction_in,
               PC_write);
    end
    reset = 1'b1;
    step();
    checks++;
    if (wr_word_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_strobe: %0d strobes busy %b want 0/0", wr_word_q.size(), busy);
    end
    fill_data(1);
    build_model(1);
    do_load(1, 1'b0, 1'b0);
    checks++;
    if (wr_word_q.size() !== 1 || wr_word_q[0] !== exp_word_q[0] || wr_pc_q[0] !== 0) begin
      errors++;
      $display("FAIL mid_reset_reload: %0d strobes first %h want 1 strobe %h@0",
               wr_word_q.size(), wr_word_q.size() > 0 ? wr_word_q[0] : 32'h0, exp_word_q[0]);
    end
  endtask

  task automatic test_ignored_start_idle_bytes();
    int a0;
    a0      = acc_cyc_q.size();
    s_valid = 1'b1;
    s_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_bytes: s_ready %b busy %b want 0/0", s_ready, busy);
      end
    end
    s_valid = 1'b0;
    checks++;
    if (acc_cyc_q.size() !== a0) begin
      errors++;
      $display("FAIL idle_accept: %0d bytes taken want 0", acc_cyc_q.size() - a0);
    end
    fill_data(3);
    build_model(3);
    do_load(3, 1'b0, 1'b1);
    checks++;
    if (wr_word_q !== exp_word_q || wr_pc_q !== exp_pc_q || acc_cyc_q.size() !== 14) begin
      errors++;
      $display("FAIL ignored_start: %0d strobes %0d bytes want 3/14", wr_word_q.size(),
               acc_cyc_q.size());
    end
  endtask

  task automatic test_random();
    int cnt, d0;
    bit tog;
    for (int it = 0; it < 12; it++) begin
      cnt = $urandom_range(0, 6);
      tog = 1'($urandom_range(0, 1));
      d0  = done_cnt;
      fill_data(cnt);
      build_model(cnt);
      do_load(cnt, tog, 1'b0);
      checks++;
      if (wr_word_q !== exp_word_q || wr_pc_q !== exp_pc_q) begin
        errors++;
        $display("FAIL rand%0d_writes: cnt %0d got %0d strobes want %0d", it, cnt,
                 wr_word_q.size(), exp_word_q.size());
      end
      checks++;
      if (error !== (cnt > int'(Depth)) || done_cnt - d0 !== 1 ||
          acc_cyc_q.size() !== 2 + 4 * cnt || core_hold !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_status: cnt %0d err %b done %0d bytes %0d hold %b", it, cnt,
                 error, done_cnt - d0, acc_cyc_q.size(), core_hold);
      end
      checks++;
      if (int'(PC_write) !== (cnt < int'(Depth) ? cnt : int'(Depth) - 1) ||
          (cnt > 0 && instruction_in !== exp_last)) begin
        errors++;
        $display("FAIL rand%0d_hold: cnt %0d pc %0d instr %h want last %h", it, cnt,
                 PC_write, instruction_in, exp_last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_overflow();
    test_reset_mid_load();
    test_ignored_start_idle_bytes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
Writer side of the core's instruction-memory load interface: accepts a byte stream (valid/ready), assembles little-endian 32-bit instructions and drives instruction_in / PC_write / reset_IF_memory into the RISC_V top. It holds the core in reset for the whole load and releases it when the last word is written. It sits between the host/UART byte receiver and the TOP instruction-load ports.

Parameters:
PC_SIZE, 10, width of PC_write; loadable depth is 2^PC_SIZE words.
CNT_W, 16, width of the word-count header field.

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to begin a load; ignored while busy
s_data  in  8  stream byte
s_valid  in  1  s_data valid
s_ready  out  1  loader accepts s_data this cycle (transfer = s_valid & s_ready)
instruction_in  out  32  assembled instruction to IF memory
PC_write  out  PC_SIZE  word index being written
reset_IF_memory  out  1  one-cycle write strobe for instruction_in at PC_write
core_hold  out  1  keeps the pipeline in reset while high
busy  out  1  load in progress
done  out  1  one-cycle pulse when the load completes
error  out  1  sticky: header count exceeded 2^PC_SIZE; cleared on next start

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE. All outputs 0: s_ready, reset_IF_memory, core_hold, busy, done, error, instruction_in, PC_write. Internal byte counter, word counter and count register cleared. Reset mid-load aborts immediately. No write strobe is issued in the reset cycle or the cycle after.
- States: IDLE, LEN_LO, LEN_HI, BYTES, WRITE, FINISH.
- IDLE: s_ready=0. start=1 -> LEN_LO. On that edge: busy=1, core_hold=1, error=0, PC_write=0.
- LEN_LO: s_ready=1. On transfer, count[7:0]=s_data -> LEN_HI.
- LEN_HI: s_ready=1. On transfer, count[15:8]=s_data.
  - If the count is 0 -> FINISH.
  - Otherwise -> BYTES with byte_idx=0.
  - If count > 2^PC_SIZE, error=1. The load proceeds.
- BYTES: s_ready=1. On transfer, byte k of the word goes into instruction_in[8k+7:8k] (byte 0 = LSB), then byte_idx++. On the 4th byte -> WRITE.
- WRITE: exactly one cycle. s_ready=0.
  - reset_IF_memory=1 only if PC_write < 2^PC_SIZE (the word is in range). Out-of-range words are consumed but not written.
  - At exit: words_done++ and PC_write++ (saturate; never wrap to 0).
  - If words_done == count -> FINISH, else -> BYTES.
- FINISH: one cycle. done=1, then -> IDLE.
  - busy and core_hold drop on the FINISH->IDLE edge.
  - instruction_in and PC_write hold their last values.
- Latency: the 4th byte of a word accepted at edge t gives reset_IF_memory high during cycle t..t+1 (the cycle after t). The next byte can be accepted at edge t+2.
- instruction_in and PC_write are stable and valid whenever reset_IF_memory=1.
- Backpressure: s_valid low stalls any receiving state indefinitely; no timeout.
- start while busy is ignored. start and reset asserted together: reset wins.
- Bytes presented while IDLE are not accepted (s_ready=0).

Decomposition:
- Shared package: state encoding constants (IDLE..FINISH), the header byte count (2), and the bytes-per-word constant (4).
- One natural sub-module, byte_word_packer: 2-bit byte index plus 32-bit shift/insert register, with load/clear and word_full output. The FSM, counters and handshake stay in imem_stream_loader.

Test Plan:
- Basic load: start, then 02 00, 13 00 10 00, 93 00 20 00 -> two strobes.
  - First strobe: instruction_in=0x00100013, PC_write=0.
  - Second strobe: instruction_in=0x00200093, PC_write=1.
  - done pulses once, then core_hold=0.
- Zero count: start, then 00 00 -> no strobe, done one cycle after the 2nd header byte, error=0.
- Backpressure: 1-word load with s_valid toggled every other cycle -> word still 0xDEADBEEF from bytes EF BE AD DE; strobe fires once; s_ready=0 during WRITE.
- Overflow: PC_SIZE=2, count=5 -> error=1 after the header; 4 strobes (PC_write 0..3); 20 data bytes consumed; done pulses; error stays set until the next start.
- Reset mid-load: drop reset after 2 of 4 data bytes -> all outputs 0 next cycle. A new start with 01 00 + 4 bytes writes a fresh word at PC_write=0, with no stale bytes.
- Ignored start / idle bytes: start pulsed during BYTES -> no effect. s_valid with bytes in IDLE -> s_ready=0 and no state change.
